arm_register_file: RTL and testbench

- ARM7-style banked register file for the core datapath.
- Three asynchronous read ports (A, B, C) and one synchronous write port over the 16 architecturally visible registers R0-R15.
- R15 is the PC and has a dedicated PC write/read path.
- Also holds CPSR plus one SPSR per privileged exception mode; the CPSR mode field selects the register bank.

---
 rtl/arm_register_file_if.sv | 38 +++
 rtl/arm_register_file.sv | 140 ++++++++++++++
 tb/tb_arm_register_file.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_register_file_if.sv
// Bus bundle for the ARM7 banked register file: three read ports, one write
// port, the dedicated PC path and the PSR read/write path.
interface arm_register_file_if #(
    parameter int ADDRLEN  = 4,
    parameter int DBUSLEN  = 32,
    parameter int FLAGSLEN = 32
);
    logic [ADDRLEN-1:0]  RF_Addr_A;
    logic [ADDRLEN-1:0]  RF_Addr_B;
    logic [ADDRLEN-1:0]  RF_Addr_C;
    logic [ADDRLEN-1:0]  RF_Addr_Write;
    logic [DBUSLEN-1:0]  RF_Bus_Write;
    logic                RF_Load_Write;
    logic [DBUSLEN-1:0]  RF_PC_Write;
    logic [FLAGSLEN-1:0] RF_Flags_Write;
    logic                RF_Load_Flags;
    logic                RF_PSR_R_Sel;
    logic                RF_PSR_W_Sel;
    logic [DBUSLEN-1:0]  RF_Bus_A;
    logic [DBUSLEN-1:0]  RF_Bus_B;
    logic [DBUSLEN-1:0]  RF_Bus_C;
    logic [DBUSLEN-1:0]  RF_PC_Read;
    logic [DBUSLEN-1:0]  RF_PSR_Read;

    modport master (
        output RF_Addr_A, RF_Addr_B, RF_Addr_C, RF_Addr_Write, RF_Bus_Write,
               RF_Load_Write, RF_PC_Write, RF_Flags_Write, RF_Load_Flags,
               RF_PSR_R_Sel, RF_PSR_W_Sel,
        input  RF_Bus_A, RF_Bus_B, RF_Bus_C, RF_PC_Read, RF_PSR_Read
    );

    modport slave (
        input  RF_Addr_A, RF_Addr_B, RF_Addr_C, RF_Addr_Write, RF_Bus_Write,
               RF_Load_Write, RF_PC_Write, RF_Flags_Write, RF_Load_Flags,
               RF_PSR_R_Sel, RF_PSR_W_Sel,
        output RF_Bus_A, RF_Bus_B, RF_Bus_C, RF_PC_Read, RF_PSR_Read
    );
endinterface

// File: rtl/arm_register_file.sv
// ARM7-style banked register file: R0-R15 with FIQ/IRQ/SVC/ABT/UND banking,
// CPSR plus one SPSR per exception mode, combinational reads, one write port.
module arm_register_file #(
    parameter int ADDRLEN  = 4,
    parameter int DBUSLEN  = 32,
    parameter int FLAGSLEN = 32
) (
    input  logic                 sysclk,
    input  logic                 reset,
    arm_register_file_if.slave   rf
);
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // Bank index: 0 = USR/SYS/invalid, 1 = FIQ, 2 = IRQ, 3 = SVC, 4 = ABT, 5 = UND
    localparam logic [2:0] BANK_USR = 3'd0;
    localparam logic [2:0] BANK_FIQ = 3'd1;

    localparam logic [FLAGSLEN-1:0] CPSR_RESET = FLAGSLEN'(32'h0000_00D3);

    function automatic logic [2:0] bank_of(input logic [4:0] mode);
        logic [2:0] bank;
        case (mode)
            MODE_USR: bank = 3'd0;
            MODE_SYS: bank = 3'd0;
            MODE_FIQ: bank = 3'd1;
            MODE_IRQ: bank = 3'd2;
            MODE_SVC: bank = 3'd3;
            MODE_ABT: bank = 3'd4;
            MODE_UND: bank = 3'd5;
            default:  bank = 3'd0;
        endcase
        return bank;
    endfunction

    logic [DBUSLEN-1:0]  low_r     [0:7];
    logic [DBUSLEN-1:0]  hi_usr_r  [0:4];
    logic [DBUSLEN-1:0]  hi_fiq_r  [0:4];
    logic [DBUSLEN-1:0]  r13_r     [0:5];
    logic [DBUSLEN-1:0]  r14_r     [0:5];
    logic [FLAGSLEN-1:0] spsr_r    [0:5];
    logic [DBUSLEN-1:0]  pc_r;
    logic [FLAGSLEN-1:0] cpsr_r;

    logic [2:0]          bank_s;
    logic                is_fiq_s;
    logic [DBUSLEN-1:0]  view_s    [0:15];
    logic [FLAGSLEN-1:0] psr_sel_s;

    assign bank_s   = bank_of(cpsr_r[4:0]);
    assign is_fiq_s = (bank_s == BANK_FIQ);

    // Flatten the currently visible bank into a 16-entry view for the read ports
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            view_s[i] = low_r[i];
        end
        for (int i = 0; i < 5; i++) begin
            view_s[i + 8] = is_fiq_s ? hi_fiq_r[i] : hi_usr_r[i];
        end
        view_s[13] = r13_r[bank_s];
        view_s[14] = r14_r[bank_s];
        view_s[15] = pc_r;
    end

    // PSR read select; modes without an SPSR fall back to CPSR
    always_comb begin
        if (rf.RF_PSR_R_Sel && (bank_s != BANK_USR)) begin
            psr_sel_s = spsr_r[bank_s];
        end else begin
            psr_sel_s = cpsr_r;
        end
    end

    assign rf.RF_Bus_A    = view_s[rf.RF_Addr_A];
    assign rf.RF_Bus_B    = view_s[rf.RF_Addr_B];
    assign rf.RF_Bus_C    = view_s[rf.RF_Addr_C];
    assign rf.RF_PC_Read  = pc_r;
    assign rf.RF_PSR_Read = DBUSLEN'(psr_sel_s);

    // Register, PC and PSR state; banking uses the pre-edge CPSR mode
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                low_r[i] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                hi_usr_r[i] <= '0;
                hi_fiq_r[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                r13_r[i]  <= '0;
                r14_r[i]  <= '0;
                spsr_r[i] <= '0;
            end
            pc_r   <= '0;
            cpsr_r <= CPSR_RESET;
        end else begin
            // An explicit R15 write below overrides this default PC update
            pc_r <= rf.RF_PC_Write;
            if (rf.RF_Load_Write) begin
                for (int i = 0; i < 8; i++) begin
                    if (rf.RF_Addr_Write == ADDRLEN'(i)) begin
                        low_r[i] <= rf.RF_Bus_Write;
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (rf.RF_Addr_Write == ADDRLEN'(i + 8)) begin
                        if (is_fiq_s) begin
                            hi_fiq_r[i] <= rf.RF_Bus_Write;
                        end else begin
                            hi_usr_r[i] <= rf.RF_Bus_Write;
                        end
                    end
                end
                if (rf.RF_Addr_Write == ADDRLEN'(13)) begin
                    r13_r[bank_s] <= rf.RF_Bus_Write;
                end
                if (rf.RF_Addr_Write == ADDRLEN'(14)) begin
                    r14_r[bank_s] <= rf.RF_Bus_Write;
                end
                if (rf.RF_Addr_Write == ADDRLEN'(15)) begin
                    pc_r <= rf.RF_Bus_Write;
                end
            end
            if (rf.RF_Load_Flags) begin
                if (!rf.RF_PSR_W_Sel) begin
                    cpsr_r <= rf.RF_Flags_Write;
                end else if (bank_s != BANK_USR) begin
                    spsr_r[bank_s] <= rf.RF_Flags_Write;
                end
            end
        end
    end
endmodule

// File: tb/tb_arm_register_file.sv
// Directed testbench for arm_register_file: reset, writes, banking, SPSR,
// PC conflict, no-bypass and synchronous reset behaviour.
module tb_arm_register_file;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    arm_register_file_if #(.ADDRLEN(4), .DBUSLEN(32), .FLAGSLEN(32)) rf_if ();

    arm_register_file #(.ADDRLEN(4), .DBUSLEN(32), .FLAGSLEN(32)) dut (
        .sysclk (clk),
        .reset  (reset),
        .rf     (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.RF_Load_Write = 1'b0;
        rf_if.RF_Load_Flags = 1'b0;
        rf_if.RF_PSR_W_Sel  = 1'b0;
    endtask

    task automatic set_mode(input logic [31:0] psr);
        rf_if.RF_Load_Flags  = 1'b1;
        rf_if.RF_PSR_W_Sel   = 1'b0;
        rf_if.RF_Flags_Write = psr;
        tick();
        idle();
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        rf_if.RF_Load_Write = 1'b1;
        rf_if.RF_Addr_Write = addr;
        rf_if.RF_Bus_Write  = data;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rf_if.RF_Addr_A = 4'd0; rf_if.RF_Addr_B = 4'd1; rf_if.RF_Addr_C = 4'd15;
        rf_if.RF_PSR_R_Sel = 1'b0;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_a got %h want %h", rf_if.RF_Bus_A, 32'h0); end
        tests_run++; if (rf_if.RF_Bus_B !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_b got %h want %h", rf_if.RF_Bus_B, 32'h0); end
        tests_run++; if (rf_if.RF_Bus_C !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_c got %h want %h", rf_if.RF_Bus_C, 32'h0); end
        tests_run++; if (rf_if.RF_PC_Read !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want %h", rf_if.RF_PC_Read, 32'h0); end
        tests_run++; if (rf_if.RF_PSR_Read !== 32'hD3) begin tests_failed++; $display("FAIL reset_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'hD3); end
        rf_if.RF_PSR_R_Sel = 1'b1;
        #1;
        tests_run++; if (rf_if.RF_PSR_Read !== 32'h0) begin tests_failed++; $display("FAIL reset_spsr_svc got %h want %h", rf_if.RF_PSR_Read, 32'h0); end
        rf_if.RF_PSR_R_Sel = 1'b0;
    endtask

    task automatic test_write_seq();
        set_mode(32'h10);
        rf_if.RF_PC_Write = 32'd4;  write_reg(4'd0, 32'hFF);
        rf_if.RF_PC_Write = 32'd8;  write_reg(4'd1, 32'hFFFF);
        rf_if.RF_PC_Write = 32'd12; write_reg(4'd2, 32'hFFF);
        rf_if.RF_PC_Write = 32'd16; write_reg(4'd3, 32'h20);
        rf_if.RF_Addr_A = 4'd0; rf_if.RF_Addr_B = 4'd1; rf_if.RF_Addr_C = 4'd2;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'hFF) begin tests_failed++; $display("FAIL wr_r0 got %h want %h", rf_if.RF_Bus_A, 32'hFF); end
        tests_run++; if (rf_if.RF_Bus_B !== 32'hFFFF) begin tests_failed++; $display("FAIL wr_r1 got %h want %h", rf_if.RF_Bus_B, 32'hFFFF); end
        tests_run++; if (rf_if.RF_Bus_C !== 32'hFFF) begin tests_failed++; $display("FAIL wr_r2 got %h want %h", rf_if.RF_Bus_C, 32'hFFF); end
        tests_run++; if (rf_if.RF_PC_Read !== 32'h10) begin tests_failed++; $display("FAIL wr_pc got %h want %h", rf_if.RF_PC_Read, 32'h10); end
        rf_if.RF_Addr_A = 4'd3;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'h20) begin tests_failed++; $display("FAIL wr_r3 got %h want %h", rf_if.RF_Bus_A, 32'h20); end
        tests_run++; if (rf_if.RF_PSR_Read !== 32'h10) begin tests_failed++; $display("FAIL wr_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'h10); end
    endtask

    task automatic test_banking();
        write_reg(4'd13, 32'h1111);
        set_mode(32'h11);
        write_reg(4'd13, 32'h2222);
        write_reg(4'd8, 32'h3333);
        rf_if.RF_Addr_A = 4'd13; rf_if.RF_Addr_B = 4'd8;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'h2222) begin tests_failed++; $display("FAIL bank_fiq_r13 got %h want %h", rf_if.RF_Bus_A, 32'h2222); end
        tests_run++; if (rf_if.RF_Bus_B !== 32'h3333) begin tests_failed++; $display("FAIL bank_fiq_r8 got %h want %h", rf_if.RF_Bus_B, 32'h3333); end
        set_mode(32'h10);
        tests_run++; if (rf_if.RF_Bus_A !== 32'h1111) begin tests_failed++; $display("FAIL bank_usr_r13 got %h want %h", rf_if.RF_Bus_A, 32'h1111); end
        tests_run++; if (rf_if.RF_Bus_B !== 32'h0) begin tests_failed++; $display("FAIL bank_usr_r8 got %h want %h", rf_if.RF_Bus_B, 32'h0); end
        // Write and mode change in the same cycle: write lands in the USR copy
        rf_if.RF_Load_Write = 1'b1; rf_if.RF_Addr_Write = 4'd9; rf_if.RF_Bus_Write = 32'h5555;
        rf_if.RF_Load_Flags = 1'b1; rf_if.RF_PSR_W_Sel = 1'b0; rf_if.RF_Flags_Write = 32'h11;
        tick();
        idle();
        rf_if.RF_Addr_C = 4'd9;
        #1;
        tests_run++; if (rf_if.RF_Bus_C !== 32'h0) begin tests_failed++; $display("FAIL bank_switch_fiq_r9 got %h want %h", rf_if.RF_Bus_C, 32'h0); end
        set_mode(32'h10);
        tests_run++; if (rf_if.RF_Bus_C !== 32'h5555) begin tests_failed++; $display("FAIL bank_switch_usr_r9 got %h want %h", rf_if.RF_Bus_C, 32'h5555); end
        set_mode(32'h15);
        tests_run++; if (rf_if.RF_Bus_A !== 32'h1111) begin tests_failed++; $display("FAIL bank_invalid_r13 got %h want %h", rf_if.RF_Bus_A, 32'h1111); end
        set_mode(32'h1F);
        tests_run++; if (rf_if.RF_Bus_A !== 32'h1111) begin tests_failed++; $display("FAIL bank_sys_r13 got %h want %h", rf_if.RF_Bus_A, 32'h1111); end
    endtask

    task automatic test_spsr();
        set_mode(32'h12);
        rf_if.RF_Load_Flags = 1'b1; rf_if.RF_PSR_W_Sel = 1'b1; rf_if.RF_Flags_Write = 32'hF000_0012;
        tick();
        idle();
        rf_if.RF_PSR_R_Sel = 1'b1;
        #1;
        tests_run++; if (rf_if.RF_PSR_Read !== 32'hF000_0012) begin tests_failed++; $display("FAIL spsr_irq got %h want %h", rf_if.RF_PSR_Read, 32'hF000_0012); end
        rf_if.RF_PSR_R_Sel = 1'b0;
        #1;
        tests_run++; if (rf_if.RF_PSR_Read !== 32'h12) begin tests_failed++; $display("FAIL spsr_irq_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'h12); end
        set_mode(32'h10);
        rf_if.RF_PSR_R_Sel = 1'b1;
        #1;
        tests_run++; if (rf_if.RF_PSR_Read !== 32'h10) begin tests_failed++; $display("FAIL spsr_usr_reads_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'h10); end
        rf_if.RF_Load_Flags = 1'b1; rf_if.RF_PSR_W_Sel = 1'b1; rf_if.RF_Flags_Write = 32'hAAAA_0000;
        tick();
        idle();
        tests_run++; if (rf_if.RF_PSR_Read !== 32'h10) begin tests_failed++; $display("FAIL spsr_usr_write_ignored got %h want %h", rf_if.RF_PSR_Read, 32'h10); end
        set_mode(32'h12);
        tests_run++; if (rf_if.RF_PSR_Read !== 32'hF000_0012) begin tests_failed++; $display("FAIL spsr_irq_kept got %h want %h", rf_if.RF_PSR_Read, 32'hF000_0012); end
        rf_if.RF_PSR_R_Sel = 1'b0;
        set_mode(32'h10);
    endtask

    task automatic test_pc_conflict();
        rf_if.RF_PC_Write = 32'h200;
        rf_if.RF_Load_Write = 1'b1; rf_if.RF_Addr_Write = 4'd15; rf_if.RF_Bus_Write = 32'h100;
        tick();
        idle();
        rf_if.RF_Addr_A = 4'd15;
        #1;
        tests_run++; if (rf_if.RF_PC_Read !== 32'h100) begin tests_failed++; $display("FAIL pc_conflict got %h want %h", rf_if.RF_PC_Read, 32'h100); end
        tests_run++; if (rf_if.RF_Bus_A !== 32'h100) begin tests_failed++; $display("FAIL pc_conflict_bus got %h want %h", rf_if.RF_Bus_A, 32'h100); end
        tick();
        tests_run++; if (rf_if.RF_PC_Read !== 32'h200) begin tests_failed++; $display("FAIL pc_next got %h want %h", rf_if.RF_PC_Read, 32'h200); end
    endtask

    task automatic test_no_bypass();
        rf_if.RF_Load_Write = 1'b1; rf_if.RF_Addr_Write = 4'd4; rf_if.RF_Bus_Write = 32'h44;
        rf_if.RF_Addr_B = 4'd4;
        #1;
        tests_run++; if (rf_if.RF_Bus_B !== 32'h0) begin tests_failed++; $display("FAIL no_bypass_before got %h want %h", rf_if.RF_Bus_B, 32'h0); end
        tick();
        idle();
        tests_run++; if (rf_if.RF_Bus_B !== 32'h44) begin tests_failed++; $display("FAIL no_bypass_after got %h want %h", rf_if.RF_Bus_B, 32'h44); end
    endtask

    task automatic test_sync_reset();
        rf_if.RF_PC_Write = 32'h300;
        rf_if.RF_Load_Write = 1'b1; rf_if.RF_Addr_Write = 4'd5; rf_if.RF_Bus_Write = 32'h55;
        rf_if.RF_Load_Flags = 1'b1; rf_if.RF_PSR_W_Sel = 1'b0; rf_if.RF_Flags_Write = 32'h11;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        rf_if.RF_Addr_A = 4'd5; rf_if.RF_Addr_B = 4'd0; rf_if.RF_Addr_C = 4'd13;
        rf_if.RF_PSR_R_Sel = 1'b0;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'h0) begin tests_failed++; $display("FAIL srst_r5 got %h want %h", rf_if.RF_Bus_A, 32'h0); end
        tests_run++; if (rf_if.RF_Bus_B !== 32'h0) begin tests_failed++; $display("FAIL srst_r0 got %h want %h", rf_if.RF_Bus_B, 32'h0); end
        tests_run++; if (rf_if.RF_Bus_C !== 32'h0) begin tests_failed++; $display("FAIL srst_r13 got %h want %h", rf_if.RF_Bus_C, 32'h0); end
        tests_run++; if (rf_if.RF_PC_Read !== 32'h0) begin tests_failed++; $display("FAIL srst_pc got %h want %h", rf_if.RF_PC_Read, 32'h0); end
        tests_run++; if (rf_if.RF_PSR_Read !== 32'hD3) begin tests_failed++; $display("FAIL srst_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'hD3); end
        // A reset pulse that never spans a rising edge must leave state intact
        rf_if.RF_PC_Write = 32'h40;
        write_reg(4'd6, 32'h66);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        rf_if.RF_Addr_A = 4'd6;
        #1;
        tests_run++; if (rf_if.RF_Bus_A !== 32'h66) begin tests_failed++; $display("FAIL pulse_r6 got %h want %h", rf_if.RF_Bus_A, 32'h66); end
        tests_run++; if (rf_if.RF_PC_Read !== 32'h40) begin tests_failed++; $display("FAIL pulse_pc got %h want %h", rf_if.RF_PC_Read, 32'h40); end
        tests_run++; if (rf_if.RF_PSR_Read !== 32'hD3) begin tests_failed++; $display("FAIL pulse_cpsr got %h want %h", rf_if.RF_PSR_Read, 32'hD3); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        rf_if.RF_Addr_A      = 4'd0;
        rf_if.RF_Addr_B      = 4'd0;
        rf_if.RF_Addr_C      = 4'd0;
        rf_if.RF_Addr_Write  = 4'd0;
        rf_if.RF_Bus_Write   = 32'h0;
        rf_if.RF_PC_Write    = 32'h0;
        rf_if.RF_Flags_Write = 32'h0;
        rf_if.RF_PSR_R_Sel   = 1'b0;
        idle();
        test_reset();
        test_write_seq();
        test_banking();
        test_spsr();
        test_pc_conflict();
        test_no_bypass();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
